instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning instruction word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 32, meaning the word count, a power of two from 4 to 1024.
REQ-003 The block SHALL have parameter ADDR_W, default 32, meaning the byte-address width.
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock, rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, meaning asynchronous active-high reset.
REQ-006 The block SHALL have port load_start, input, 1 bit, meaning a pulse that enters load mode and clears the word count.
REQ-007 The block SHALL have ports load_valid (input, 1), load_data (input, DATA_W), load_last (input, 1) and load_ready (output, 1), meaning the program-load handshake.
REQ-008 The block SHALL have ports req_valid (input, 1), readAddress (input, ADDR_W) and req_ready (output, 1), meaning the fetch request.
REQ-009 The block SHALL have ports resp_valid (output, 1), instruction (output, DATA_W), addr_err (output, 1) and resp_ready (input, 1), meaning the fetch response.
REQ-010 The block SHALL have port loaded_count, output, clog2(DEPTH)+1 bits, meaning the number of valid words.

Function
REQ-011 The block SHALL implement the FSM states S_EMPTY, S_LOAD and S_RUN.
REQ-012 In S_EMPTY, the block SHALL move to S_LOAD on load_start, and a fetch SHALL NOT be accepted.
REQ-013 In S_LOAD, load_ready SHALL be 1, and each load_valid&load_ready beat SHALL write mem[loaded_count] and increment loaded_count.
REQ-014 An accepted beat with load_last=1, or the beat that makes loaded_count equal DEPTH, SHALL move the FSM to S_RUN on the next cycle.
REQ-015 Beats offered after loaded_count reaches DEPTH SHALL NOT be accepted, because load_ready is 0 outside S_LOAD.
REQ-016 req_ready SHALL equal (state==S_RUN) & (!resp_valid | resp_ready), and SHALL NOT depend on req_valid.
REQ-017 An accepted request SHALL produce resp_valid=1 on the next clock with instruction = mem[readAddress>>2], giving one-cycle latency.
REQ-018 Full throughput of one request per cycle SHALL be sustained while resp_ready is 1.
REQ-019 While resp_valid=1 and resp_ready=0, the instruction and addr_err outputs SHALL hold stable.
REQ-020 A word index at or above loaded_count SHALL return instruction=0.
REQ-021 load_start in S_RUN SHALL move the FSM to S_LOAD and zero loaded_count, while a request accepted in the same cycle completes with the old contents.
REQ-022 A pending response SHALL persist across entry to S_LOAD until it is consumed.
REQ-023 load_start in S_LOAD SHALL restart the load at word 0, and a simultaneous beat SHALL be discarded.

Reset
REQ-024 Reset SHALL force state=S_EMPTY, loaded_count=0, resp_valid=0, instruction=0, addr_err=0, load_ready=0 and req_ready=0.
REQ-025 Reset SHALL NOT clear the memory array; reads are gated by loaded_count.
REQ-026 Reset mid-load or mid-response SHALL drop all in-flight state.

Configuration
REQ-027 With IMEM_BOUNDS_CHECK_EN defined, a misaligned address (readAddress[1:0]!=0) or an index >= DEPTH SHALL return instruction=0 with addr_err=1 in the response cycle.
REQ-028 Without IMEM_BOUNDS_CHECK_EN, the index SHALL be (readAddress>>2) mod DEPTH, the low bits SHALL be ignored, and addr_err SHALL be tied 0.

Structure
REQ-029 The FSM state enum and the word-offset constant (2) SHALL reside in the shared package imem_pkg.
REQ-030 The storage array SHALL be one sub-module, imem_array, with one synchronous write port and one synchronous read port.

Verification
REQ-031 The bench SHALL cover basic load and fetch: load 0x20080005, 0x20090003, 0x01095020 with last on the third beat, then fetch 0x8 -> next cycle instruction=0x01095020, loaded_count=3.
REQ-032 The bench SHALL cover the unloaded index: after the 3-word load above, fetch 0x10 -> instruction=0 with addr_err=0.
REQ-033 The bench SHALL cover back-pressure: issue fetches of 0x0 and 0x4 with resp_ready=0 for 3 cycles -> instruction holds 0x20080005 and req_ready=0, then the second response follows one cycle after release.
REQ-034 The bench SHALL cover the full load: with DEPTH=32, stream 40 beats without last -> exactly 32 are accepted and the FSM enters S_RUN.
REQ-035 The bench SHALL cover bounds checking with IMEM_BOUNDS_CHECK_EN: fetch 0x6 -> addr_err=1 and instruction=0; without the macro, fetch 0x84 returns word 1.
REQ-036 The bench SHALL cover reset: assert reset during a load beat -> the next cycle shows loaded_count=0, resp_valid=0, and req_ready=0 until a reload completes.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction fetch memory.
package imem_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // Byte address to word index shift for 32-bit instruction words.
    localparam int WORD_OFS = 2;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one synchronous read port.
// Contents are deliberately not reset; readers gate by the loaded word count.
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int IW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [IW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // The read register only moves on rd_en so a stalled response holds.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a one-cycle-latency fetch port.
// Optional IMEM_BOUNDS_CHECK_EN flags misaligned / out-of-range fetches via addr_err.
module instr_fetch_mem
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       load_start,
    input  logic                       load_valid,
    input  logic [DATA_W-1:0]          load_data,
    input  logic                       load_last,
    output logic                       load_ready,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          readAddress,
    output logic                       req_ready,
    output logic                       resp_valid,
    output logic [DATA_W-1:0]          instruction,
    output logic                       addr_err,
    input  logic                       resp_ready,
    output logic [$clog2(DEPTH):0]     loaded_count
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

`ifdef IMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    state_t             state;
    logic               run_q;
    logic [CW-1:0]      count;
    logic               hit_q;
    logic               err_q;
    logic [DATA_W-1:0]  rd_data;

    logic               beat;
    logic               accept;
    logic [ADDR_W-1:0]  word_addr;
    logic [IW-1:0]      idx;
    logic               misaligned;
    logic               over;
    logic               bad;
    logic               in_range;

    // A beat coinciding with load_start is dropped: the load restarts at word 0.
    assign beat       = load_valid & load_ready & ~load_start;
    assign req_ready  = run_q & (~resp_valid | resp_ready);
    assign accept     = req_valid & req_ready;

    assign word_addr  = readAddress >> WORD_OFS;
    assign idx        = word_addr[IW-1:0];
    assign misaligned = |readAddress[WORD_OFS-1:0];
    assign over       = word_addr >= ADDR_W'(DEPTH);
    assign bad        = BOUNDS_EN & (misaligned | over);
    assign in_range   = {1'b0, idx} < count;

    assign loaded_count = count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_EMPTY;
            load_ready <= 1'b0;
            run_q      <= 1'b0;
            count      <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (load_start) begin
                        state      <= S_LOAD;
                        load_ready <= 1'b1;
                        count      <= '0;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        count <= '0;
                    end else if (beat) begin
                        count <= count + CW'(1);
                        if (load_last || count == CW'(DEPTH - 1)) begin
                            state      <= S_RUN;
                            load_ready <= 1'b0;
                            run_q      <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (load_start) begin
                        state      <= S_LOAD;
                        load_ready <= 1'b1;
                        run_q      <= 1'b0;
                        count      <= '0;
                    end
                end
                default: begin
                    state      <= S_EMPTY;
                    load_ready <= 1'b0;
                    run_q      <= 1'b0;
                    count      <= '0;
                end
            endcase
        end
    end

    // Hit is judged against the count at accept time, so a fetch racing a
    // reload still sees the old program.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid <= 1'b0;
            hit_q      <= 1'b0;
            err_q      <= 1'b0;
        end else if (accept) begin
            resp_valid <= 1'b1;
            hit_q      <= in_range & ~bad;
            err_q      <= bad;
        end else if (resp_ready) begin
            resp_valid <= 1'b0;
        end
    end

    assign instruction = hit_q ? rd_data : '0;
    assign addr_err    = err_q;

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IW     (IW)
    ) u_array (
        .clk     (clk),
        .wr_en   (beat),
        .wr_addr (count[IW-1:0]),
        .wr_data (load_data),
        .rd_en   (accept),
        .rd_addr (idx),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Scoreboard bench for instr_fetch_mem: directed scenarios plus random traffic,
// checked against a word-level reference model of the program memory.
module tb_instr_fetch_mem;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 32;
    localparam int CW     = $clog2(DEPTH) + 1;

    logic              clk;
    logic              reset;
    logic              load_start;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_ready;
    logic              req_valid;
    logic [ADDR_W-1:0] readAddress;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] instruction;
    logic              addr_err;
    logic              resp_ready;
    logic [CW-1:0]     loaded_count;

    instr_fetch_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .load_start   (load_start),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_last    (load_last),
        .load_ready   (load_ready),
        .req_valid    (req_valid),
        .readAddress  (readAddress),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .instruction  (instruction),
        .addr_err     (addr_err),
        .resp_ready   (resp_ready),
        .loaded_count (loaded_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: the program as an array of words plus a word count.
    typedef struct packed {
        logic [DATA_W-1:0] ins;
        logic              err;
    } exp_t;

    logic [DATA_W-1:0] m_mem [DEPTH];
    int                m_cnt  = 0;
    int                m_mode = 0;   // 0 empty, 1 loading, 2 running
    bit                m_pend = 0;
    exp_t              sb[$];

    function automatic exp_t predict(input logic [ADDR_W-1:0] a);
        exp_t        e;
        int unsigned w;
        int unsigned k;
        w = a / 4;
        e.err = 1'b0;
        e.ins = '0;
`ifdef IMEM_BOUNDS_CHECK_EN
        if ((a % 4) != 0 || w >= DEPTH) begin
            e.err = 1'b1;
        end else if (w < m_cnt) begin
            e.ins = m_mem[w];
        end
`else
        k = w % DEPTH;
        if (k < m_cnt)
            e.ins = m_mem[k];
`endif
        return e;
    endfunction

    // Model: checks handshake outputs, predicts responses, applies loads.
    always @(negedge clk) begin
        bit exp_rr;
        if (reset) begin
            m_mode = 0;
            m_cnt  = 0;
            m_pend = 0;
            sb.delete();
            chk("rst_resp_valid", resp_valid, 0);
            chk("rst_instruction", instruction, 0);
            chk("rst_addr_err", addr_err, 0);
            chk("rst_loaded_count", loaded_count, 0);
            chk("rst_req_ready", req_ready, 0);
            chk("rst_load_ready", load_ready, 0);
        end else begin
            exp_rr = (m_mode == 2) && (!m_pend || resp_ready);
            chk("req_ready", req_ready, exp_rr);
            chk("load_ready", load_ready, m_mode == 1);
            chk("loaded_count", loaded_count, m_cnt);
            chk("resp_valid", resp_valid, m_pend);
            if (req_valid && exp_rr) begin
                sb.push_back(predict(readAddress));
                m_pend = 1;
            end else if (resp_ready) begin
                m_pend = 0;
            end
            if (load_start) begin
                m_mode = 1;
                m_cnt  = 0;
            end else if (m_mode == 1 && load_valid) begin
                m_mem[m_cnt] = load_data;
                m_cnt++;
                if (load_last || m_cnt == DEPTH)
                    m_mode = 2;
            end
        end
    end

    // Monitor: compares every presented response with the scoreboard head.
    always @(negedge clk) begin
        if (!reset && resp_valid) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_resp: got instruction 0x%0h with empty scoreboard at %0t",
                         instruction, $time);
            end else begin
                chk("resp_instruction", instruction, sb[0].ins);
                chk("resp_addr_err", addr_err, sb[0].err);
                if (resp_ready)
                    void'(sb.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        load_start = 0;
        load_valid = 0;
        load_last  = 0;
        req_valid  = 0;
    endtask

    task automatic beat(input logic [DATA_W-1:0] d, input logic last);
        load_valid = 1;
        load_data  = d;
        load_last  = last;
        tick();
        load_valid = 0;
        load_last  = 0;
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a);
        req_valid   = 1;
        readAddress = a;
        tick();
        req_valid   = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    logic [DATA_W-1:0] word1;

    initial begin
        reset = 1; idle(); load_data = '0; readAddress = '0; resp_ready = 1;
        repeat (2) tick();
        reset = 0;
        tick();

        // Basic 3-word program, last on third beat
        load_start = 1; tick(); load_start = 0;
        beat(32'h20080005, 0);
        beat(32'h20090003, 0);
        beat(32'h01095020, 1);
        fetch(32'h8);
        @(negedge clk);
        chk("basic_instr", instruction, 32'h01095020);
        chk("basic_count", loaded_count, 3);
        tick();
        fetch(32'h10);
        @(negedge clk);
        chk("unloaded_instr", instruction, 0);
        chk("unloaded_err", addr_err, 0);
        tick();

        // Back-pressure: second request waits while the first is held
        resp_ready = 0;
        fetch(32'h0);
        req_valid = 1; readAddress = 32'h4;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_hold_instr", instruction, 32'h20080005);
            chk("bp_req_ready", req_ready, 0);
            tick();
        end
        resp_ready = 1;
        tick();
        req_valid = 0;
        @(negedge clk);
        chk("bp_second_instr", instruction, 32'h20090003);
        chk("bp_second_valid", resp_valid, 1);
        tick();

        // Full load: 40 beats offered, only DEPTH accepted
        load_start = 1; tick(); load_start = 0;
        load_valid = 1;
        for (int i = 0; i < 40; i++) begin
            load_data = $urandom;
            if (i == 1) word1 = load_data;
            tick();
        end
        load_valid = 0;
        @(negedge clk);
        chk("full_count", loaded_count, DEPTH);
        chk("full_run_req_ready", req_ready, 1);
        tick();

        fetch(32'h84);
        @(negedge clk);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("oob_err", addr_err, 1);
        chk("oob_instr", instruction, 0);
`else
        chk("alias_instr", instruction, word1);
        chk("alias_err", addr_err, 0);
`endif
        tick();
        fetch(32'h6);
        @(negedge clk);
`ifdef IMEM_BOUNDS_CHECK_EN
        chk("misalign_err", addr_err, 1);
        chk("misalign_instr", instruction, 0);
`else
        chk("misalign_ignored_instr", instruction, word1);
        chk("misalign_err_tied", addr_err, 0);
`endif
        tick();

        // Reload from RUN with a simultaneous stalled fetch of old contents
        resp_ready = 0;
        req_valid = 1; readAddress = 32'h4; load_start = 1;
        tick();
        idle();
        repeat (2) tick();
        resp_ready = 1;
        tick();
        // Restart mid-load; the coincident beat is discarded
        beat(32'hdeadbeef, 0);
        load_start = 1; load_valid = 1; load_data = 32'h11111111;
        tick();
        idle();
        beat(32'h22222222, 0);
        beat(32'h33333333, 1);
        fetch(32'h0);
        fetch(32'h4);
        fetch(32'h8);
        tick();

        // Reset in the middle of a load beat
        load_start = 1; tick(); load_start = 0;
        beat(32'h44444444, 0);
        load_valid = 1; load_data = 32'h55555555; reset = 1;
        @(negedge clk);
        chk("rstload_count", loaded_count, 0);
        chk("rstload_resp_valid", resp_valid, 0);
        chk("rstload_req_ready", req_ready, 0);
        tick();
        reset = 0; idle();
        req_valid = 1; readAddress = 32'h0;
        repeat (3) tick();
        req_valid = 0;
        load_start = 1; tick(); load_start = 0;
        for (int i = 0; i < 5; i++) beat($urandom, i == 4);
        for (int i = 0; i < 6; i++) fetch(i * 4);

        // Random traffic
        for (int c = 0; c < 700; c++) begin
            reset       = ($urandom_range(0, 299) == 0);
            resp_ready  = ($urandom_range(0, 3) != 0);
            req_valid   = $urandom_range(0, 1);
            readAddress = $urandom_range(0, DEPTH * 8 - 1);
            load_start  = ($urandom_range(0, 63) == 0);
            load_valid  = $urandom_range(0, 1);
            load_data   = $urandom;
            load_last   = ($urandom_range(0, 7) == 0);
            tick();
        end

        reset = 0; idle(); resp_ready = 1;
        repeat (3) tick();
        chk("drain_scoreboard", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
